oblk_fifo_framer: RTL and testbench

//  Drain stage directly downstream of the RAM-to-FIFO reorder stage. Collects per-output-block info records
//  (LANES channels) and the matching per-lane show-ahead FIFOs. Round-robin picks a lane, emits one block header,

---
 rtl/oblk_fifo_framer_pkg.sv | 34 +++
 rtl/oblk_fifo_framer_rr_lane_arbiter.sv | 43 ++++
 rtl/oblk_fifo_framer.sv | 192 +++++++++++++++++++
 tb/tb_oblk_fifo_framer.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oblk_fifo_framer_pkg.sv
// ----------------------------------------------------------------------------
// oblk_fifo_framer_pkg
// Shared definitions for the output-block FIFO framer:
//   - framer FSM state encoding
//   - block-info (BI_valid) sideband codes
//   - bit offsets of the fields inside a packed info record
//     {FDSSI, SSI, STI, BLEN}, with BLEN in the least significant bits
// ----------------------------------------------------------------------------
package oblk_fifo_framer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] BI_NONE = 2'b00;
    localparam logic [1:0] BI_HDR  = 2'b01;

    // The record is packed MSB-first as FDSSI, SSI, STI, BLEN.
    function automatic int sti_lsb(input int blen_w);
        return blen_w;
    endfunction

    function automatic int ssi_lsb(input int blen_w, input int sti_w);
        return blen_w + sti_w;
    endfunction

    function automatic int fdssi_lsb(input int blen_w, input int sti_w, input int ssi_w);
        return blen_w + sti_w + ssi_w;
    endfunction

endpackage

// File: rtl/oblk_fifo_framer_rr_lane_arbiter.sv
// ----------------------------------------------------------------------------
// rr_lane_arbiter
// Purely combinational round-robin pick: scans the request vector starting at
// 'ptr' and wrapping upward, and grants the first requesting lane.
// Ports:
//   req        in   LANES   per-lane request
//   ptr        in   IDX_W   lane where the scan begins
//   grant      out  LANES   one-hot grant (all zero when nobody requests)
//   grant_idx  out  IDX_W   index of the granted lane
//   grant_any  out  1       at least one lane was granted
// ----------------------------------------------------------------------------
module rr_lane_arbiter
    import oblk_fifo_framer_pkg::*;
#(
    parameter int LANES = 4,
    parameter int IDX_W = 2
) (
    input  logic [LANES-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [LANES-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    logic [IDX_W-1:0] scan_idx;

    // LANES is a power of two, so plain IDX_W-bit addition gives the wrap.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        scan_idx  = '0;
        for (int k = 0; k < LANES; k++) begin
            scan_idx = ptr + IDX_W'(k);
            if (!grant_any && req[scan_idx]) begin
                grant_any       = 1'b1;
                grant_idx       = scan_idx;
                grant[scan_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/oblk_fifo_framer.sv
// ----------------------------------------------------------------------------
// oblk_fifo_framer
// Drain stage after the RAM-to-FIFO reorder stage. Picks a lane round-robin,
// accepts its info record, emits a one-cycle block header on SDMFo_d_BI_valid
// and then streams BLEN words from that lane's show-ahead FIFO as one AXI-S
// packet.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   info_tvalid/tready/info  per-lane info records {FDSSI,SSI,STI,BLEN}
//   fifo_rdreq/q/empty       per-lane show-ahead FIFO interface
//   SDMFo_d_t*               AXI-S data beats (tvalid/tready/tlast/tkeep/tdata)
//   SDMFo_d_FDSSI/SSI/STI/BL header fields of the current block
//   SDMFo_d_BI_valid         2'b01 for one cycle at the header
//   SDMFo_d_frame_valid      high through the data phase
//   blk_lane, blk_done       lane of the current block, end-of-block pulse
// ----------------------------------------------------------------------------
module oblk_fifo_framer
    import oblk_fifo_framer_pkg::*;
#(
    parameter int FIFO_NUM_OBLK   = 2,
    parameter int I_DATA_WIDTH    = 24,
    parameter int I_FDSSI_WIDTH   = 12,
    parameter int I_SSI_WIDTH     = 8,
    parameter int I_STI_WIDTH     = 8,
    parameter int INBL_CNT_MAX    = 8,
    parameter int I_BL_WIDTH      = 16,
    parameter int INFO_DATA_WIDTH = I_FDSSI_WIDTH + I_SSI_WIDTH + I_STI_WIDTH + INBL_CNT_MAX,
    localparam int LANES          = 2 ** FIFO_NUM_OBLK,
    localparam int KEEP_W         = I_DATA_WIDTH / 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [LANES-1:0]                 info_tvalid,
    output logic [LANES-1:0]                 info_tready,
    input  logic [LANES*INFO_DATA_WIDTH-1:0] info,
    output logic [LANES-1:0]                 fifo_rdreq,
    input  logic [LANES*I_DATA_WIDTH-1:0]    fifo_q,
    input  logic [LANES-1:0]                 fifo_empty,
    output logic                             SDMFo_d_tvalid,
    input  logic                             SDMFo_d_tready,
    output logic                             SDMFo_d_tlast,
    output logic [KEEP_W-1:0]                SDMFo_d_tkeep,
    output logic [I_DATA_WIDTH-1:0]          SDMFo_d_tdata,
    output logic [I_FDSSI_WIDTH-1:0]         SDMFo_d_FDSSI,
    output logic [I_SSI_WIDTH-1:0]           SDMFo_d_SSI,
    output logic [I_STI_WIDTH-1:0]           SDMFo_d_STI,
    output logic [I_BL_WIDTH-1:0]            SDMFo_d_BL,
    output logic [1:0]                       SDMFo_d_BI_valid,
    output logic                             SDMFo_d_frame_valid,
    output logic [FIFO_NUM_OBLK-1:0]         blk_lane,
    output logic                             blk_done
);

    localparam int STI_LSB   = sti_lsb(INBL_CNT_MAX);
    localparam int SSI_LSB   = ssi_lsb(INBL_CNT_MAX, I_STI_WIDTH);
    localparam int FDSSI_LSB = fdssi_lsb(INBL_CNT_MAX, I_STI_WIDTH, I_SSI_WIDTH);

    state_t state, state_next;

    logic [INFO_DATA_WIDTH-1:0] info_lane [LANES];
    logic [I_DATA_WIDTH-1:0]    q_lane    [LANES];

    logic [LANES-1:0]           grant;
    logic [FIFO_NUM_OBLK-1:0]   grant_idx;
    logic                       grant_any;
    logic [FIFO_NUM_OBLK-1:0]   rr_ptr;
    logic [FIFO_NUM_OBLK-1:0]   lane;

    logic [I_FDSSI_WIDTH-1:0]   fdssi;
    logic [I_SSI_WIDTH-1:0]     ssi;
    logic [I_STI_WIDTH-1:0]     sti;
    logic [INBL_CNT_MAX-1:0]    blen;
    logic [INBL_CNT_MAX-1:0]    beat_cnt;

    logic [INFO_DATA_WIDTH-1:0] granted_rec;
    logic                       accept;
    logic                       in_data;
    logic                       data_avail;
    logic                       last_beat;
    logic                       beat_fire;

    for (genvar g = 0; g < LANES; g++) begin : g_unpack
        assign info_lane[g] = info[g*INFO_DATA_WIDTH +: INFO_DATA_WIDTH];
        assign q_lane[g]    = fifo_q[g*I_DATA_WIDTH +: I_DATA_WIDTH];
    end

    rr_lane_arbiter #(
        .LANES (LANES),
        .IDX_W (FIFO_NUM_OBLK)
    ) u_arb (
        .req       (info_tvalid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // A record is only taken while idle and never during reset, so an
    // upstream record is not lost on a reset cycle.
    assign granted_rec = info_lane[grant_idx];
    assign accept      = (state == ST_IDLE) && grant_any && !rst;
    assign in_data     = (state == ST_DATA);
    assign data_avail  = in_data && !fifo_empty[lane];
    assign last_beat   = (beat_cnt == blen - INBL_CNT_MAX'(1));
    assign beat_fire   = data_avail && SDMFo_d_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A zero-length record is consumed in IDLE without producing a header.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept && (granted_rec[INBL_CNT_MAX-1:0] != '0)) state_next = ST_HDR;
            ST_HDR:  state_next = ST_DATA;
            ST_DATA: if (beat_fire && last_beat) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Record latch, round-robin pointer and beat counter. Header fields are
    // held from one accept to the next so downstream can sample them late.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            lane     <= '0;
            fdssi    <= '0;
            ssi      <= '0;
            sti      <= '0;
            blen     <= '0;
            beat_cnt <= '0;
        end else begin
            if (accept) begin
                rr_ptr   <= grant_idx + FIFO_NUM_OBLK'(1);
                lane     <= grant_idx;
                fdssi    <= granted_rec[FDSSI_LSB +: I_FDSSI_WIDTH];
                ssi      <= granted_rec[SSI_LSB +: I_SSI_WIDTH];
                sti      <= granted_rec[STI_LSB +: I_STI_WIDTH];
                blen     <= granted_rec[INBL_CNT_MAX-1:0];
                beat_cnt <= '0;
            end else if (beat_fire) begin
                beat_cnt <= beat_cnt + INBL_CNT_MAX'(1);
            end
        end
    end

    // Only the granted / current lane ever sees info_tready or fifo_rdreq.
    always_comb begin
        info_tready         = '0;
        fifo_rdreq          = '0;
        SDMFo_d_tvalid      = 1'b0;
        SDMFo_d_tlast       = 1'b0;
        SDMFo_d_tkeep       = '0;
        SDMFo_d_tdata       = '0;
        SDMFo_d_BI_valid    = BI_NONE;
        SDMFo_d_frame_valid = 1'b0;
        blk_done            = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) info_tready = grant;
            end
            ST_HDR: begin
                SDMFo_d_BI_valid = BI_HDR;
            end
            ST_DATA: begin
                SDMFo_d_frame_valid = 1'b1;
                SDMFo_d_tvalid      = data_avail;
                SDMFo_d_tdata       = q_lane[lane];
                SDMFo_d_tlast       = last_beat;
                SDMFo_d_tkeep       = {KEEP_W{data_avail}};
                fifo_rdreq[lane]    = beat_fire;
            end
            ST_DONE: begin
                blk_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign SDMFo_d_FDSSI = fdssi;
    assign SDMFo_d_SSI   = ssi;
    assign SDMFo_d_STI   = sti;
    assign SDMFo_d_BL    = I_BL_WIDTH'(blen);
    assign blk_lane      = lane;

endmodule

// File: tb/tb_oblk_fifo_framer.sv
// ----------------------------------------------------------------------------
// tb_oblk_fifo_framer
// Scoreboard bench: each scenario task loads lane FIFO / info queues and
// pushes the header, beats and done pulse it expects; a negedge monitor pops
// and compares them as the framer produces output.
// ----------------------------------------------------------------------------
module tb_oblk_fifo_framer;

    localparam int LN = 4;
    localparam int DW = 24;
    localparam int IW = 36;

    localparam logic [1:0] K_HDR  = 2'd0;
    localparam logic [1:0] K_BEAT = 2'd1;
    localparam logic [1:0] K_DONE = 2'd2;

    typedef struct packed {
        logic [1:0]    kind;
        logic [1:0]    lane;
        logic [IW-1:0] rec;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [LN-1:0]     info_tvalid = '0;
    logic [LN-1:0]     info_tready;
    logic [LN*IW-1:0]  info = '0;
    logic [LN-1:0]     fifo_rdreq;
    logic [LN*DW-1:0]  fifo_q = '0;
    logic [LN-1:0]     fifo_empty = '1;
    logic              SDMFo_d_tvalid;
    logic              SDMFo_d_tready;
    logic              SDMFo_d_tlast;
    logic [2:0]        SDMFo_d_tkeep;
    logic [DW-1:0]     SDMFo_d_tdata;
    logic [11:0]       SDMFo_d_FDSSI;
    logic [7:0]        SDMFo_d_SSI;
    logic [7:0]        SDMFo_d_STI;
    logic [15:0]       SDMFo_d_BL;
    logic [1:0]        SDMFo_d_BI_valid;
    logic              SDMFo_d_frame_valid;
    logic [1:0]        blk_lane;
    logic              blk_done;

    logic [DW-1:0] fq [LN][$];
    logic [IW-1:0] iq [LN][$];
    exp_t          exp_q [$];

    int check_cnt = 0;
    int pass_cnt  = 0;
    int cyc       = 0;
    int beat_seen = 0;
    int done_seen = 0;
    int hdr_cyc   = 0;
    int first_beat_cyc = 0;
    int done_cyc  = 0;
    bit pending_first = 1'b0;

    oblk_fifo_framer dut (
        .clk                 (clk),
        .rst                 (rst),
        .info_tvalid         (info_tvalid),
        .info_tready         (info_tready),
        .info                (info),
        .fifo_rdreq          (fifo_rdreq),
        .fifo_q              (fifo_q),
        .fifo_empty          (fifo_empty),
        .SDMFo_d_tvalid      (SDMFo_d_tvalid),
        .SDMFo_d_tready      (SDMFo_d_tready),
        .SDMFo_d_tlast       (SDMFo_d_tlast),
        .SDMFo_d_tkeep       (SDMFo_d_tkeep),
        .SDMFo_d_tdata       (SDMFo_d_tdata),
        .SDMFo_d_FDSSI       (SDMFo_d_FDSSI),
        .SDMFo_d_SSI         (SDMFo_d_SSI),
        .SDMFo_d_STI         (SDMFo_d_STI),
        .SDMFo_d_BL          (SDMFo_d_BL),
        .SDMFo_d_BI_valid    (SDMFo_d_BI_valid),
        .SDMFo_d_frame_valid (SDMFo_d_frame_valid),
        .blk_lane            (blk_lane),
        .blk_done            (blk_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Show-ahead FIFO and info source models: handshakes are sampled at the
    // edge, the queues advance just after it.
    always @(posedge clk) begin : src_model
        logic [LN-1:0] rd;
        logic [LN-1:0] tr;
        rd = fifo_rdreq;
        tr = info_tready;
        #1;
        for (int i = 0; i < LN; i++) begin
            if (rd[i] && fq[i].size() > 0) void'(fq[i].pop_front());
            if (tr[i] && iq[i].size() > 0) void'(iq[i].pop_front());
            fifo_empty[i]          = (fq[i].size() == 0);
            fifo_q[i*DW +: DW]     = (fq[i].size() > 0) ? fq[i][0] : '0;
            info_tvalid[i]         = (iq[i].size() > 0);
            info[i*IW +: IW]       = (iq[i].size() > 0) ? iq[i][0] : '0;
        end
    end

    // Output monitor: pops the scoreboard on headers, accepted beats and done.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (SDMFo_d_BI_valid !== 2'b00) begin
                check_cnt++;
                hdr_cyc = cyc;
                pending_first = 1'b1;
                if (exp_q.size() == 0) begin
                    $display("[TB] FAIL hdr_unexpected: got lane %0d BL %0d BI %b, required no header",
                             blk_lane, SDMFo_d_BL, SDMFo_d_BI_valid);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind === K_HDR && SDMFo_d_BI_valid === 2'b01 &&
                        {blk_lane, SDMFo_d_FDSSI, SDMFo_d_SSI, SDMFo_d_STI, SDMFo_d_BL} ===
                        {e.lane, e.rec[35:8], 8'h00, e.rec[7:0]})
                        pass_cnt++;
                    else
                        $display("[TB] FAIL hdr: got kind HDR lane %0d fields %h/%h/%h BL %h BI %b, required kind %0d lane %0d rec %h",
                                 blk_lane, SDMFo_d_FDSSI, SDMFo_d_SSI, SDMFo_d_STI, SDMFo_d_BL,
                                 SDMFo_d_BI_valid, e.kind, e.lane, e.rec);
                end
            end
            if (SDMFo_d_tvalid === 1'b1 && SDMFo_d_tready === 1'b1) begin
                check_cnt++;
                beat_seen++;
                if (pending_first) begin
                    first_beat_cyc = cyc;
                    pending_first  = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    $display("[TB] FAIL beat_unexpected: got data %h last %b, required no beat",
                             SDMFo_d_tdata, SDMFo_d_tlast);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind === K_BEAT &&
                        {SDMFo_d_tdata, SDMFo_d_tlast, SDMFo_d_tkeep, fifo_rdreq} ===
                        {e.data, e.last, 3'b111, 4'(4'b0001 << e.lane)})
                        pass_cnt++;
                    else
                        $display("[TB] FAIL beat: got data %h last %b keep %b rdreq %b, required kind %0d data %h last %b keep 111 lane %0d",
                                 SDMFo_d_tdata, SDMFo_d_tlast, SDMFo_d_tkeep, fifo_rdreq,
                                 e.kind, e.data, e.last, e.lane);
                end
            end else begin
                check_cnt++;
                if (fifo_rdreq === 4'b0000) pass_cnt++;
                else $display("[TB] FAIL rdreq_no_handshake: got %b, required 0000", fifo_rdreq);
            end
            if (blk_done !== 1'b0) begin
                check_cnt++;
                done_seen++;
                done_cyc = cyc;
                if (exp_q.size() == 0) begin
                    $display("[TB] FAIL done_unexpected: got blk_done %b lane %0d, required none", blk_done, blk_lane);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind === K_DONE && blk_done === 1'b1 && blk_lane === e.lane) pass_cnt++;
                    else $display("[TB] FAIL done: got lane %0d, required kind %0d lane %0d", blk_lane, e.kind, e.lane);
                end
            end
        end
    end

    task automatic push_block(input int lane, input int blen, input logic [DW-1:0] base, input int preload);
        exp_t e;
        logic [IW-1:0] rec;
        rec = {12'hA00 + 12'(lane * 16 + blen), 8'h30 + 8'(lane), 8'h50 + 8'(blen), 8'(blen)};
        for (int k = 0; k < preload; k++) fq[lane].push_back(base + DW'(k));
        iq[lane].push_back(rec);
        if (blen != 0) begin
            e = '{kind: K_HDR, lane: 2'(lane), rec: rec, data: '0, last: 1'b0};
            exp_q.push_back(e);
            for (int k = 0; k < blen; k++) begin
                e = '{kind: K_BEAT, lane: 2'(lane), rec: rec, data: base + DW'(k), last: (k == blen - 1)};
                exp_q.push_back(e);
            end
            e = '{kind: K_DONE, lane: 2'(lane), rec: rec, data: '0, last: 1'b0};
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #2;
        check_cnt++;
        if (exp_q.size() == 0) pass_cnt++;
        else $display("[TB] FAIL drain_%s: got %0d items outstanding, required 0", name, exp_q.size());
    endtask

    task automatic wait_beats(input int target, input string name);
        int n = 0;
        while (beat_seen < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (beat_seen < target) begin
            check_cnt++;
            $display("[TB] FAIL timeout_%s: got %0d beats, required %0d", name, beat_seen, target);
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < LN; i++) begin
            fq[i].delete();
            iq[i].delete();
        end
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        SDMFo_d_tready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        iq[0].push_back(36'h123456703);
        repeat (2) @(negedge clk);
        check_cnt++;
        if ({info_tready, fifo_rdreq, SDMFo_d_tvalid, SDMFo_d_BI_valid, blk_done, SDMFo_d_frame_valid} === '0) pass_cnt++;
        else $display("[TB] FAIL reset_ctrl: got tready %b rdreq %b tvalid %b BI %b done %b fv %b, required all 0",
                      info_tready, fifo_rdreq, SDMFo_d_tvalid, SDMFo_d_BI_valid, blk_done, SDMFo_d_frame_valid);
        check_cnt++;
        if ({SDMFo_d_FDSSI, SDMFo_d_SSI, SDMFo_d_STI, SDMFo_d_BL, blk_lane, SDMFo_d_tdata, SDMFo_d_tkeep, SDMFo_d_tlast} === '0) pass_cnt++;
        else $display("[TB] FAIL reset_fields: got %h/%h/%h BL %h lane %0d data %h, required 0",
                      SDMFo_d_FDSSI, SDMFo_d_SSI, SDMFo_d_STI, SDMFo_d_BL, blk_lane, SDMFo_d_tdata);
        @(posedge clk);
        #2;
        iq[0].delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic test_single();
        int done0 = done_seen;
        push_block(0, 3, 24'h00A000, 3);
        wait_drain(100, "single");
        check_cnt++;
        if (done_seen - done0 == 1) pass_cnt++;
        else $display("[TB] FAIL single_done_count: got %0d, required 1", done_seen - done0);
        check_cnt++;
        if (first_beat_cyc - hdr_cyc == 1) pass_cnt++;
        else $display("[TB] FAIL single_hdr_to_beat: got %0d cycles, required 1", first_beat_cyc - hdr_cyc);
        check_cnt++;
        if (done_cyc - hdr_cyc == 4) pass_cnt++;
        else $display("[TB] FAIL single_hdr_to_done: got %0d cycles, required 4", done_cyc - hdr_cyc);
    endtask

    task automatic test_round_robin();
        int d0 = done_seen;
        int n  = 0;
        for (int l = 0; l < LN; l++) push_block(l, 1, 24'h100000 + DW'(l * 256), 1);
        while (done_seen == d0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #2;
        push_block(0, 1, 24'h1A0000, 1);
        wait_drain(200, "round_robin");
    endtask

    task automatic test_stall();
        int b0 = beat_seen;
        push_block(1, 4, 24'h300000, 4);
        wait_beats(b0 + 1, "stall");
        SDMFo_d_tready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check_cnt++;
            if ({SDMFo_d_tvalid, SDMFo_d_tdata, SDMFo_d_tlast, fifo_rdreq} === {1'b1, 24'h300001, 1'b0, 4'b0000}) pass_cnt++;
            else $display("[TB] FAIL stall_hold: got tvalid %b data %h last %b rdreq %b, required 1 300001 0 0000",
                          SDMFo_d_tvalid, SDMFo_d_tdata, SDMFo_d_tlast, fifo_rdreq);
        end
        @(posedge clk);
        #2;
        SDMFo_d_tready = 1'b1;
        wait_drain(100, "stall");
    endtask

    task automatic test_empty_gap();
        int b0 = beat_seen;
        push_block(3, 2, 24'h400000, 1);
        wait_beats(b0 + 1, "gap");
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            check_cnt++;
            if ({SDMFo_d_tvalid, SDMFo_d_frame_valid, fifo_rdreq} === {1'b0, 1'b1, 4'b0000}) pass_cnt++;
            else $display("[TB] FAIL gap_idle: got tvalid %b frame_valid %b rdreq %b, required 0 1 0000",
                          SDMFo_d_tvalid, SDMFo_d_frame_valid, fifo_rdreq);
        end
        @(posedge clk);
        #2;
        fq[3].push_back(24'h400001);
        wait_drain(100, "gap");
    endtask

    task automatic test_zero_blen();
        apply_reset();
        push_block(2, 0, 24'h500000, 0);
        push_block(3, 1, 24'h5B0000, 1);
        wait_drain(100, "zero_blen");
        check_cnt++;
        if (iq[2].size() == 0 && iq[3].size() == 0) pass_cnt++;
        else $display("[TB] FAIL zero_consumed: got %0d/%0d records left on lanes 2/3, required 0/0",
                      iq[2].size(), iq[3].size());
    endtask

    task automatic test_reset_mid();
        int b0;
        apply_reset();
        b0 = beat_seen;
        push_block(0, 8, 24'h600000, 8);
        wait_beats(b0 + 3, "reset_mid");
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_cnt++;
        if ({SDMFo_d_tvalid, SDMFo_d_tlast, SDMFo_d_tkeep, SDMFo_d_tdata, SDMFo_d_BI_valid, SDMFo_d_frame_valid,
             blk_done, blk_lane, SDMFo_d_FDSSI, SDMFo_d_SSI, SDMFo_d_STI, SDMFo_d_BL, fifo_rdreq, info_tready} === '0) pass_cnt++;
        else $display("[TB] FAIL reset_mid_outputs: got tvalid %b data %h fv %b lane %0d BL %h rdreq %b, required all 0",
                      SDMFo_d_tvalid, SDMFo_d_tdata, SDMFo_d_frame_valid, blk_lane, SDMFo_d_BL, fifo_rdreq);
        exp_q.delete();
        fq[0].delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        push_block(0, 1, 24'h6A0000, 1);
        push_block(1, 1, 24'h6B0000, 1);
        wait_drain(100, "after_reset");
    endtask

    initial begin
        rst = 1'b1;
        SDMFo_d_tready = 1'b1;
        test_reset();
        test_single();
        apply_reset();
        test_round_robin();
        test_stall();
        test_empty_gap();
        test_zero_blen();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
